// File: rtl/l2_amo_seq.sv
// l2_amo_seq: runs one atomic memory operation at a time through the L2
// read-modify-write path.
//   - IDLE accepts a request and captures op/addr/size/operand line.
//   - The data-array port is requested and then held locked from the first
//     request cycle through the write-back, so no other agent can slip
//     between the read and the write of the same index.
//   - The read line goes to the external combinational AMO ALU. Its result is
//     written back unless the op is a NOP. The pre-modification line is
//     returned to the requester.
// Ports:
//   req_*        request handshake and payload from the L2 AMO issue point
//   arr_*        data-array port: lock/grant, read strobe, write strobe, index, data
//   alu_*        operands to / result from the combinational AMO ALU
//   resp_*       response handshake carrying the old line
//   busy         high whenever an operation is in flight
module l2_amo_seq #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 40,
    parameter int OP_WIDTH    = 4,
    parameter int SIZE_WIDTH  = 3,
    parameter int INDEX_WIDTH = 10,
    parameter int INDEX_LO    = 4,
    parameter int READ_LAT    = 1,
    parameter int NOP_OP      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [OP_WIDTH-1:0]    req_op,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [SIZE_WIDTH-1:0]  req_size,
    input  logic [DATA_WIDTH-1:0]  req_data,
    output logic                   arr_req,
    input  logic                   arr_gnt,
    output logic                   arr_rd_en,
    output logic                   arr_wr_en,
    output logic [INDEX_WIDTH-1:0] arr_index,
    output logic [DATA_WIDTH-1:0]  arr_wr_data,
    input  logic [DATA_WIDTH-1:0]  arr_rd_data,
    output logic [OP_WIDTH-1:0]    alu_op,
    output logic [ADDR_WIDTH-1:0]  alu_address,
    output logic [SIZE_WIDTH-1:0]  alu_data_size,
    output logic [DATA_WIDTH-1:0]  alu_mem_operand,
    output logic [DATA_WIDTH-1:0]  alu_cpu_operand,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [DATA_WIDTH-1:0]  resp_data,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ACQ, S_WAIT, S_EXEC, S_WRITE, S_RESP
    } state_e;

    // Counter reload value: WAIT then lasts exactly READ_LAT cycles.
    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [OP_WIDTH-1:0]     op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SIZE_WIDTH-1:0]   size_q, size_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   mem_q, mem_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    in_idle;
    logic                    is_nop;

    assign in_idle = (state_q == S_IDLE);
    assign is_nop  = (op_q == OP_WIDTH'(NOP_OP));

    // NOTE: every register here is a plain flop (no storage array), so all of
    // them are cleared by reset; this keeps the data outputs at 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            mem_q   <= '0;
            res_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            mem_q   <= mem_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        size_d    = size_q;
        data_d    = data_q;
        mem_d     = mem_q;
        res_d     = res_q;
        req_rdy   = 1'b0;
        arr_req   = 1'b0;
        arr_rd_en = 1'b0;
        arr_wr_en = 1'b0;
        resp_val  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Reset forces the state to IDLE asynchronously; masking with
                // rst keeps req_rdy low for as long as reset is held.
                req_rdy = ~rst;
                if (req_val) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    data_d  = req_data;
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                arr_req   = 1'b1;
                // The read is launched in the very cycle the port is won.
                arr_rd_en = arr_gnt;
                if (arr_gnt) begin
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                arr_req = 1'b1;
                if (cnt_q == 3'd0) begin
                    mem_d   = arr_rd_data;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_EXEC: begin
                arr_req = 1'b1;
                res_d   = alu_result;
                state_d = is_nop ? S_RESP : S_WRITE;
            end
            S_WRITE: begin
                arr_req   = 1'b1;
                arr_wr_en = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Data outputs come straight from registers and are zero while idle.
    assign arr_index       = in_idle ? '0 : addr_q[INDEX_LO +: INDEX_WIDTH];
    assign arr_wr_data     = (state_q == S_WRITE) ? res_q : '0;
    assign resp_data       = (state_q == S_RESP) ? mem_q : '0;
    assign alu_op          = in_idle ? '0 : op_q;
    assign alu_address     = in_idle ? '0 : addr_q;
    assign alu_data_size   = in_idle ? '0 : size_q;
    assign alu_mem_operand = in_idle ? '0 : mem_q;
    assign alu_cpu_operand = in_idle ? '0 : data_q;
    assign busy            = ~in_idle;

endmodule

// File: tb/tb_l2_amo_seq.sv
// Bench for l2_amo_seq: two instances (READ_LAT 1 and 3) driven with
// directed and random traffic, checked every cycle against a timeline model
// built from the acceptance and grant cycles of each operation.
module tb_l2_amo_seq;

    localparam int DW  = 128;
    localparam int AW  = 40;
    localparam int OW  = 4;
    localparam int SW  = 3;
    localparam int IW  = 10;
    localparam int ILO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    task automatic check(input int inst, input string name,
                         input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL rl%0d %s: got %0h, expected %0h", inst, name, got, exp);
        end
    endtask

    // Reference AMO ALU: operates on the 64-bit lane picked by addr[3];
    // only 8-byte size (3) is supported, anything else leaves the line as is.
    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                            input logic [AW-1:0] addr,
                                            input logic [SW-1:0] size,
                                            input logic [DW-1:0] mem,
                                            input logic [DW-1:0] cpu);
        logic [DW-1:0] r;
        logic [63:0]   m, o;
        int            lane;
        r    = mem;
        lane = int'(addr[3]);
        m    = mem[lane*64 +: 64];
        o    = cpu[lane*64 +: 64];
        if (size == 3'd3) begin
            case (op)
                4'd1: r[lane*64 +: 64] = m + o;
                4'd2: r[lane*64 +: 64] = m ^ o;
                4'd3: r[lane*64 +: 64] = o;
                4'd4: r[lane*64 +: 64] = (m > o) ? m : o;
                default: ;
            endcase
        end
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int RL = (g == 0) ? 1 : 3;

        logic          rst;
        logic          req_val, req_rdy;
        logic [OW-1:0] req_op;
        logic [AW-1:0] req_addr;
        logic [SW-1:0] req_size;
        logic [DW-1:0] req_data;
        logic          arr_req, arr_gnt, arr_rd_en, arr_wr_en;
        logic [IW-1:0] arr_index;
        logic [DW-1:0] arr_wr_data, arr_rd_data;
        logic [OW-1:0] alu_op;
        logic [AW-1:0] alu_address;
        logic [SW-1:0] alu_data_size;
        logic [DW-1:0] alu_mem_operand, alu_cpu_operand, alu_result;
        logic          resp_val, resp_rdy;
        logic [DW-1:0] resp_data;
        logic          busy;

        l2_amo_seq #(.READ_LAT(RL)) dut (
            .clk(clk), .rst(rst),
            .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op),
            .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
            .arr_req(arr_req), .arr_gnt(arr_gnt), .arr_rd_en(arr_rd_en),
            .arr_wr_en(arr_wr_en), .arr_index(arr_index),
            .arr_wr_data(arr_wr_data), .arr_rd_data(arr_rd_data),
            .alu_op(alu_op), .alu_address(alu_address),
            .alu_data_size(alu_data_size), .alu_mem_operand(alu_mem_operand),
            .alu_cpu_operand(alu_cpu_operand), .alu_result(alu_result),
            .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
            .busy(busy)
        );

        assign alu_result = alu_f(alu_op, alu_address, alu_data_size,
                                  alu_mem_operand, alu_cpu_operand);

        // Array contents and model of the operation in flight.
        logic [DW-1:0] mem [1024];
        int            c;
        bit            act, granted;
        int            t_gnt;
        logic [OW-1:0] m_op;
        logic [AW-1:0] m_addr;
        logic [SW-1:0] m_size;
        logic [DW-1:0] m_cpu, m_old, m_res;

        // Stimulus knobs: 0 random, 1 fixed, 2 directed/scheduled.
        int            req_mode, gnt_mode, rdy_mode;
        int            gnt_from, rdy_from;
        logic [OW-1:0] d_op;
        logic [AW-1:0] d_addr;
        logic [SW-1:0] d_size;
        logic [DW-1:0] d_data;

        // Observed event cycles relative to the first recorded acceptance.
        int            rec_t0, rd_rel, wr_rel, resp_rel, wr_cnt, nrdy, acc2;
        logic [IW-1:0] wr_idx;
        logic [DW-1:0] wr_dat, resp_dat;

        function automatic logic [IW-1:0] idx_of(input logic [AW-1:0] a);
            return a[ILO +: IW];
        endfunction

        function automatic logic [DW-1:0] rnd_line();
            return {$urandom, $urandom, $urandom, $urandom};
        endfunction

        task automatic rec_clear();
            rec_t0 = -1; rd_rel = -1; wr_rel = -1; resp_rel = -1;
            wr_cnt = 0; nrdy = 0; acc2 = -1;
        endtask

        task automatic step();
            bit            was_act, e_acq, e_rd, e_exec, e_wr, e_resp, e_req, nop;
            int            k, rel;
            logic [IW-1:0] e_idx;
            @(posedge clk);
            #1;
            c++;
            case (req_mode)
                0:       req_val = ($urandom_range(0, 2) == 0);
                1:       req_val = 1'b0;
                default: req_val = 1'b1;
            endcase
            if (req_mode == 2) begin
                req_op = d_op; req_addr = d_addr; req_size = d_size; req_data = d_data;
            end else begin
                req_op   = OW'($urandom_range(0, 5));
                req_addr = {8'($urandom), $urandom};
                req_addr[ILO +: IW] = IW'($urandom_range(0, 7));
                req_size = ($urandom_range(0, 3) != 0) ? 3'd3 : SW'($urandom);
                req_data = rnd_line();
            end
            case (gnt_mode)
                0:       arr_gnt = 1'($urandom_range(0, 1));
                1:       arr_gnt = 1'b1;
                default: arr_gnt = (c >= gnt_from);
            endcase
            case (rdy_mode)
                0:       resp_rdy = 1'($urandom_range(0, 1));
                1:       resp_rdy = 1'b1;
                default: resp_rdy = (c >= rdy_from);
            endcase
            // Valid read data appears only READ_LAT cycles after the grant;
            // every other cycle carries junk.
            if (act && granted && (c - t_gnt == RL)) arr_rd_data = mem[idx_of(m_addr)];
            else                                     arr_rd_data = rnd_line();

            @(negedge clk);
            was_act = act;
            nop     = (m_op == '0);
            k       = c - t_gnt;
            e_acq   = act && !granted;
            e_rd    = e_acq && arr_gnt;
            e_exec  = act && granted && (k == RL + 1);
            e_wr    = act && granted && !nop && (k == RL + 2);
            e_resp  = act && granted && (k >= RL + (nop ? 2 : 3));
            e_req   = act && !e_resp;
            e_idx   = act ? idx_of(m_addr) : '0;

            check(RL, "req_rdy",   DW'(req_rdy),   DW'(!act));
            check(RL, "busy",      DW'(busy),      DW'(act));
            check(RL, "arr_req",   DW'(arr_req),   DW'(e_req));
            check(RL, "arr_rd_en", DW'(arr_rd_en), DW'(e_rd));
            check(RL, "arr_wr_en", DW'(arr_wr_en), DW'(e_wr));
            check(RL, "resp_val",  DW'(resp_val),  DW'(e_resp));
            check(RL, "arr_index", DW'(arr_index), DW'(e_idx));
            if (e_wr)   check(RL, "arr_wr_data", arr_wr_data, m_res);
            if (e_resp) check(RL, "resp_data", resp_data, m_old);
            if (e_exec) begin
                check(RL, "alu_mem_operand", alu_mem_operand, m_old);
                check(RL, "alu_cpu_operand", alu_cpu_operand, m_cpu);
                check(RL, "alu_op",          DW'(alu_op),        DW'(m_op));
                check(RL, "alu_address",     DW'(alu_address),   DW'(m_addr));
                check(RL, "alu_data_size",   DW'(alu_data_size), DW'(m_size));
            end
            if (!act) begin
                check(RL, "idle_mem_operand", alu_mem_operand, '0);
                check(RL, "idle_cpu_operand", alu_cpu_operand, '0);
            end

            if (rec_t0 >= 0) begin
                rel = c - rec_t0;
                if (arr_rd_en && rd_rel < 0) rd_rel = rel;
                if (arr_wr_en) begin
                    wr_cnt++;
                    if (wr_rel < 0) begin
                        wr_rel = rel; wr_idx = arr_index; wr_dat = arr_wr_data;
                    end
                end
                if (resp_val && resp_rel < 0) begin
                    resp_rel = rel; resp_dat = resp_data;
                end
                if (!req_rdy) nrdy++;
            end

            if (e_rd) begin
                granted = 1'b1;
                t_gnt   = c;
            end
            if (e_wr) mem[idx_of(m_addr)] = m_res;
            if (e_resp && resp_rdy) act = 1'b0;
            if (!was_act && req_val) begin
                act     = 1'b1;
                granted = 1'b0;
                m_op    = req_op;
                m_addr  = req_addr;
                m_size  = req_size;
                m_cpu   = req_data;
                m_old   = mem[idx_of(req_addr)];
                m_res   = alu_f(req_op, req_addr, req_size, m_old, req_data);
                if (rec_t0 < 0)    rec_t0 = c;
                else if (acc2 < 0) acc2 = c - rec_t0;
            end
        endtask

        task automatic drain();
            req_mode = 1; gnt_mode = 1; rdy_mode = 1;
            for (int i = 0; i < 60 && act; i++) step();
            step();
        endtask

        // One directed request presented for a single cycle on an idle DUT.
        task automatic issue(input logic [OW-1:0] op, input logic [IW-1:0] idx,
                             input logic [DW-1:0] cpu);
            d_op = op; d_size = 3'd3; d_data = cpu;
            d_addr = '0;
            d_addr[ILO +: IW] = idx;
            rec_clear();
            req_mode = 2;
            step();
            req_mode = 1;
        endtask

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = rnd_line();
            act = 1'b0; granted = 1'b0; t_gnt = 0; c = 0;
            m_op = '0; m_addr = '0; m_size = '0; m_cpu = '0; m_old = '0; m_res = '0;
            gnt_from = 0; rdy_from = 0;
            rec_clear();
            rst = 1'b1; req_val = 1'b0; req_op = '0; req_addr = '0; req_size = '0;
            req_data = '0; arr_gnt = 1'b0; resp_rdy = 1'b0; arr_rd_data = '0;

            @(negedge clk);
            check(RL, "reset_req_rdy",   DW'(req_rdy),   '0);
            check(RL, "reset_busy",      DW'(busy),      '0);
            check(RL, "reset_arr_req",   DW'(arr_req),   '0);
            check(RL, "reset_arr_index", DW'(arr_index), '0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            drain();

            // ADD, 8 bytes at 0x40 (index 4): mem dword 5 + cpu 3.
            mem[4] = {64'd0, 64'd5};
            gnt_mode = 1; rdy_mode = 1;
            issue(4'd1, 10'h004, {64'd0, 64'd3});
            repeat (8) step();
            check(RL, "lit_rd_cycle",   DW'(rd_rel),   DW'(1));
            check(RL, "lit_wr_cycle",   DW'(wr_rel),   DW'(3 + RL));
            check(RL, "lit_wr_index",   DW'(wr_idx),   DW'(10'h004));
            check(RL, "lit_wr_data",    wr_dat,        {64'd0, 64'd8});
            check(RL, "lit_resp_cycle", DW'(resp_rel), DW'(4 + RL));
            check(RL, "lit_resp_data",  resp_dat,      {64'd0, 64'd5});
            check(RL, "lit_rdy_low",    DW'(nrdy),     DW'(4 + RL));
            drain();

            // Grant withheld for the first three ACQ cycles.
            gnt_mode = 2; gnt_from = c + 1 + 4; rdy_mode = 1;
            issue(4'd2, 10'h005, rnd_line());
            gnt_mode = 2;
            repeat (12) step();
            check(RL, "lit_gnt_rd_cycle",   DW'(rd_rel),   DW'(4));
            check(RL, "lit_gnt_wr_cycle",   DW'(wr_rel),   DW'(6 + RL));
            check(RL, "lit_gnt_resp_cycle", DW'(resp_rel), DW'(7 + RL));
            drain();

            // NOP: no write-back, response one cycle earlier.
            gnt_mode = 1; rdy_mode = 1;
            issue(4'd0, 10'h006, rnd_line());
            repeat (8) step();
            check(RL, "lit_nop_wr_count",  DW'(wr_cnt),   DW'(0));
            check(RL, "lit_nop_resp_cycle", DW'(resp_rel), DW'(3 + RL));
            drain();

            // Response stalled 4 cycles while a second request waits.
            gnt_mode = 1; rdy_mode = 2; rdy_from = c + 1 + 8 + RL;
            d_op = 4'd3; d_size = 3'd3; d_data = rnd_line();
            d_addr = '0; d_addr[ILO +: IW] = 10'h007;
            rec_clear();
            req_mode = 2;
            repeat (10 + RL) step();
            req_mode = 1;
            check(RL, "lit_second_accept", DW'(acc2), DW'(9 + RL));
            drain();

            // Reset asserted during WAIT.
            gnt_mode = 1; rdy_mode = 1;
            issue(4'd1, 10'h002, rnd_line());
            step();
            @(posedge clk);
            #1;
            c++;
            req_val = 1'b0; arr_gnt = 1'b1; resp_rdy = 1'b0;
            #2;
            rst = 1'b1;
            #1;
            check(RL, "rst_req_rdy",   DW'(req_rdy),   '0);
            check(RL, "rst_busy",      DW'(busy),      '0);
            check(RL, "rst_arr_req",   DW'(arr_req),   '0);
            check(RL, "rst_arr_rd_en", DW'(arr_rd_en), '0);
            check(RL, "rst_arr_wr_en", DW'(arr_wr_en), '0);
            check(RL, "rst_resp_val",  DW'(resp_val),  '0);
            check(RL, "rst_arr_index", DW'(arr_index), '0);
            check(RL, "rst_cpu_operand", alu_cpu_operand, '0);
            act = 1'b0; granted = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check(RL, "rst_hold_wr_en", DW'(arr_wr_en), '0);
                check(RL, "rst_hold_arr_req", DW'(arr_req), '0);
            end
            @(posedge clk);
            #1;
            c++;
            rst = 1'b0;
            step();
            issue(4'd1, 10'h003, rnd_line());
            repeat (8) step();
            check(RL, "lit_post_rst_resp", DW'(resp_rel), DW'(4 + RL));
            drain();

            // Random traffic: random requests, grants and response stalls.
            req_mode = 0; gnt_mode = 0; rdy_mode = 0;
            repeat (600) step();
            drain();

            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && n_done < 2; i++) @(posedge clk);
        check(0, "both_instances_done", DW'(n_done), DW'(2));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
